// File: rtl/cpu_pkg.sv
// Shared encodings for the single-step processor: FSM states, opcodes,
// destination fields and the decoded-instruction record.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALT      = 3'd4
   } state_e;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_SHL   = 4'd4;
   localparam logic [3:0] OP_SHR   = 4'd5;
   localparam logic [3:0] OP_SQA   = 4'd6;
   localparam logic [3:0] OP_SQB   = 4'd7;
   localparam logic [3:0] OP_STORE = 4'd8;
   localparam logic [3:0] OP_LDA   = 4'd9;
   localparam logic [3:0] OP_LDB   = 4'd10;
   localparam logic [3:0] OP_OUT   = 4'd11;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [1:0] DEST_A = 2'b00;
   localparam logic [1:0] DEST_B = 2'b01;

   // Source selected onto the write bus during EXECUTE
   typedef enum logic [2:0] {
      WS_HOLD = 3'd0,
      WS_ALU  = 3'd1,
      WS_SWA  = 3'd2,
      WS_SWB  = 3'd3,
      WS_AREG = 3'd4,
      WS_BREG = 3'd5
   } wsrc_e;

   typedef struct packed {
      logic  is_alu;
      wsrc_e wsrc;
      logic  lat_a;
      logic  lat_b;
      logic  lat_o;
      logic  is_halt;
   } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/ROM signal bundle. The sequencer is the master;
// the datapath, ROM and switches form the slave side.
interface control_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              run;
   logic [DATA_W-1:0] instr;
   logic [DATA_W-1:0] sw_a;
   logic [DATA_W-1:0] sw_b;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] alu_out;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] w_bus;
   logic              latch_a;
   logic              latch_b;
   logic              latch_o;
   logic [2:0]        state;
   logic              halted;

   modport master (
      input  run, instr, sw_a, sw_b, a_reg, b_reg, alu_out,
      output pc, ir, alu_sel, w_bus, latch_a, latch_b, latch_o, state, halted
   );

   modport slave (
      output run, instr, sw_a, sw_b, a_reg, b_reg, alu_out,
      input  pc, ir, alu_sel, w_bus, latch_a, latch_b, latch_o, state, halted
   );
endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decode: opcode and destination field (ir[7:2])
// to ALU/halt flags, write-bus source and register strobe selection.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [5:0] op_dest_i,
   output dec_t       dec_o
);

   logic [3:0] op_s;
   logic [1:0] dest_s;

   assign op_s   = op_dest_i[5:2];
   assign dest_s = op_dest_i[1:0];

   // Decode opcode into control fields; ir[3]==1 targets no register
   always_comb begin
      dec_o      = '0;
      dec_o.wsrc = WS_HOLD;
      case (op_s)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV,
         OP_SHL, OP_SHR, OP_SQA, OP_SQB: begin
            dec_o.is_alu = 1'b1;
         end
         OP_STORE: begin
            dec_o.wsrc  = WS_ALU;
            dec_o.lat_a = (dest_s == DEST_A);
            dec_o.lat_b = (dest_s == DEST_B);
         end
         OP_LDA: begin
            dec_o.wsrc  = WS_SWA;
            dec_o.lat_a = (dest_s == DEST_A);
            dec_o.lat_b = (dest_s == DEST_B);
         end
         OP_LDB: begin
            dec_o.wsrc  = WS_SWB;
            dec_o.lat_b = 1'b1;
         end
         OP_OUT: begin
            dec_o.wsrc  = (dest_s == DEST_A) ? WS_AREG : WS_BREG;
            dec_o.lat_o = 1'b1;
         end
         OP_HALT: begin
            dec_o.is_halt = 1'b1;
         end
         default: begin
            dec_o.wsrc = WS_HOLD;
         end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute/writeback controller: owns PC, IR, ALU select and the
// write bus, and pulses one register strobe per instruction in WRITEBACK.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic                one_shot_clock,
   input  logic                reset,
   control_sequencer_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [3:0]        alu_sel_q, alu_sel_d;
   logic [DATA_W-1:0] w_bus_q, w_bus_d;
   logic              step_s;
   dec_t              dec_s;

   instr_decoder u_dec (
      .op_dest_i (ir_q[7:2]),
      .dec_o     (dec_s)
   );

   assign step_s = bus.run && (state_q != ST_HALT);

   // State register
   always_ff @(posedge one_shot_clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; HALT is terminal until reset
   always_comb begin
      state_d = state_q;
      if (step_s) begin
         case (state_q)
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = dec_s.is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_HALT;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Datapath-register next values and combinational outputs
   always_comb begin
      pc_d        = pc_q;
      ir_d        = ir_q;
      alu_sel_d   = alu_sel_q;
      w_bus_d     = w_bus_q;
      bus.latch_a = 1'b0;
      bus.latch_b = 1'b0;
      bus.latch_o = 1'b0;
      bus.halted  = (state_q == ST_HALT);
      if (step_s) begin
         case (state_q)
            ST_FETCH: begin
               ir_d = bus.instr;
            end
            ST_DECODE: begin
               // Non-ALU ops keep the last select so a later store sees its result
               if (dec_s.is_alu) begin
                  alu_sel_d = ir_q[7:4];
               end else begin
                  alu_sel_d = alu_sel_q;
               end
            end
            ST_EXECUTE: begin
               case (dec_s.wsrc)
                  WS_ALU:  w_bus_d = bus.alu_out;
                  WS_SWA:  w_bus_d = bus.sw_a;
                  WS_SWB:  w_bus_d = bus.sw_b;
                  WS_AREG: w_bus_d = bus.a_reg;
                  WS_BREG: w_bus_d = bus.b_reg;
                  default: w_bus_d = w_bus_q;
               endcase
            end
            ST_WRITEBACK: begin
               pc_d        = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               bus.latch_a = dec_s.lat_a;
               bus.latch_b = dec_s.lat_b;
               bus.latch_o = dec_s.lat_o;
            end
            default: begin
               pc_d = pc_q;
            end
         endcase
      end else begin
         pc_d = pc_q;
      end
   end

   // Registered datapath outputs
   always_ff @(posedge one_shot_clock) begin
      if (reset) begin
         pc_q      <= {ADDR_W{1'b0}};
         ir_q      <= {DATA_W{1'b0}};
         alu_sel_q <= 4'd0;
         w_bus_q   <= {DATA_W{1'b0}};
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_sel_q <= alu_sel_d;
         w_bus_q   <= w_bus_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.ir      = ir_q;
   assign bus.alu_sel = alu_sel_q;
   assign bus.w_bus   = w_bus_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer with hand-computed expectations.
module tb_control_sequencer;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   strobe_hits;

   control_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   control_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
      .one_shot_clock (clk),
      .reset          (reset),
      .bus            (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] strobes();
      return {bus.latch_o, bus.latch_b, bus.latch_a};
   endfunction

   // One full instruction; strobe vector is {o,b,a}
   task automatic do_instr(input logic [7:0] op, input logic [7:0] exp_wbus,
                           input logic [2:0] exp_strb, input logic [7:0] exp_pc);
      bus.instr = op;
      step();
      check_vec("ir", bus.ir, op);
      step();
      step();
      check_vec("w_bus", bus.w_bus, exp_wbus);
      check_vec("wb_strobes", strobes(), exp_strb);
      step();
      check_vec("pc", bus.pc, exp_pc);
      check_vec("fetch_strobes", strobes(), 3'b000);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      strobe_hits = 0;
      reset       = 1'b1;
      bus.run     = 1'b1;
      bus.instr   = 8'h00;
      bus.sw_a    = 8'h00;
      bus.sw_b    = 8'h00;
      bus.a_reg   = 8'h00;
      bus.b_reg   = 8'h00;
      bus.alu_out = 8'h00;
      step();
      step();
      reset = 1'b0;

      // Reset mid-instruction, in EXECUTE with run high
      bus.instr = 8'h90;
      bus.sw_a  = 8'h2A;
      step();
      step();
      check_vec("pre_rst_state", bus.state, 3'd2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_vec("rst_state", bus.state, 3'd0);
      check_vec("rst_pc", bus.pc, 8'h00);
      check_vec("rst_ir", bus.ir, 8'h00);
      check_vec("rst_w_bus", bus.w_bus, 8'h00);
      check_vec("rst_strobes", strobes(), 3'b000);
      check_vec("rst_halted", bus.halted, 1'b0);

      // Load A walked edge by edge
      step();
      check_vec("lda_ir", bus.ir, 8'h90);
      check_vec("lda_st1", bus.state, 3'd1);
      step();
      check_vec("lda_st2", bus.state, 3'd2);
      step();
      check_vec("lda_w_bus", bus.w_bus, 8'h2A);
      check_vec("lda_st3", bus.state, 3'd3);
      check_vec("lda_strobes", strobes(), 3'b001);
      step();
      check_vec("lda_pc", bus.pc, 8'h01);
      check_vec("lda_st0", bus.state, 3'd0);
      check_vec("lda_strb_off", strobes(), 3'b000);

      // ALU select retained across a store
      do_instr(8'h20, 8'h2A, 3'b000, 8'h02);
      check_vec("mul_alu_sel", bus.alu_sel, 4'd2);
      bus.alu_out = 8'h35;
      do_instr(8'h84, 8'h35, 3'b010, 8'h03);
      check_vec("st_alu_sel", bus.alu_sel, 4'd2);
      do_instr(8'h00, 8'h35, 3'b000, 8'h04);
      check_vec("add_alu_sel", bus.alu_sel, 4'd0);

      // Output from B / A, load with no destination, NOP
      bus.a_reg = 8'h77;
      bus.b_reg = 8'h11;
      do_instr(8'hB4, 8'h11, 3'b100, 8'h05);
      do_instr(8'hB0, 8'h77, 3'b100, 8'h06);
      bus.sw_a = 8'h55;
      do_instr(8'h98, 8'h55, 3'b000, 8'h07);
      do_instr(8'hC0, 8'h55, 3'b000, 8'h08);

      // run low freezes EXECUTE, then suppresses the WRITEBACK strobe
      bus.sw_b  = 8'h66;
      bus.instr = 8'hA0;
      step();
      step();
      check_vec("frz_state", bus.state, 3'd2);
      bus.run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_vec("frz_hold_state", bus.state, 3'd2);
         check_vec("frz_w_bus", bus.w_bus, 8'h55);
         check_vec("frz_strobes", strobes(), 3'b000);
      end
      bus.run = 1'b1;
      step();
      check_vec("ldb_w_bus", bus.w_bus, 8'h66);
      check_vec("ldb_strobes", strobes(), 3'b010);
      bus.run = 1'b0;
      #1;
      check_vec("ldb_run0_strb", strobes(), 3'b000);
      step();
      check_vec("ldb_run0_st", bus.state, 3'd3);
      check_vec("ldb_run0_pc", bus.pc, 8'h08);
      bus.run = 1'b1;
      step();
      check_vec("ldb_pc", bus.pc, 8'h09);

      // HALT is sticky regardless of run
      bus.instr = 8'hF0;
      step();
      step();
      check_vec("halt_state", bus.state, 3'd4);
      check_vec("halt_flag", bus.halted, 1'b1);
      for (int i = 0; i < 10; i++) begin
         bus.run   = ~bus.run;
         bus.instr = 8'h90;
         step();
         check_vec("halt_pc", bus.pc, 8'h09);
         check_vec("halt_st", bus.state, 3'd4);
         check_vec("halt_ir", bus.ir, 8'hF0);
         check_vec("halt_strobes", strobes(), 3'b000);
      end
      check_vec("halt_w_bus", bus.w_bus, 8'h66);
      check_vec("halt_alu_sel", bus.alu_sel, 4'd0);
      bus.run = 1'b1;
      reset   = 1'b1;
      step();
      reset = 1'b0;
      check_vec("unhalt_state", bus.state, 3'd0);
      check_vec("unhalt_pc", bus.pc, 8'h00);
      check_vec("unhalt_flag", bus.halted, 1'b0);

      // 256 NOPs: PC wraps 0xFF -> 0x00 with no strobes
      bus.instr = 8'hC0;
      for (int n = 0; n < 256; n++) begin
         for (int e = 0; e < 4; e++) begin
            step();
            if (strobes() != 3'b000) strobe_hits++;
         end
         if (n == 254) check_vec("nop_pc_ff", bus.pc, 8'hFF);
      end
      check_vec("nop_pc_wrap", bus.pc, 8'h00);
      check_vec("nop_state", bus.state, 3'd0);
      check_vec("nop_halted", bus.halted, 1'b0);
      check_vec("nop_strobes", strobe_hits, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback controller for the 8-bit single-step processor. It sits between the program ROM and the A/B/OUT register file plus ALU. It drives the ROM address (PC) and holds the instruction register. It generates the ALU select, the write-bus data and one-cycle register latch strobes, so the top level needs no ad-hoc control. It advances one state per one_shot_clock edge while run is high.

Parameters:
DATA_W, 8, datapath width (bus, registers, switch operands)
ADDR_W, 8, program counter / ROM address width

Ports:
one_shot_clock  in   1       debounced single-step clock
reset           in   1       synchronous, active-high
run             in   1       step enable; low freezes the FSM
instr           in   DATA_W  ROM output at address pc
sw_a            in   DATA_W  switch operand A
sw_b            in   DATA_W  switch operand B
a_reg           in   DATA_W  current A register value
b_reg           in   DATA_W  current B register value
alu_out         in   DATA_W  combinational ALU result
pc              out  ADDR_W  ROM address
ir              out  DATA_W  latched instruction
alu_sel         out  4       ALU operation select
w_bus           out  DATA_W  write-bus data to A/B/OUT registers
latch_a         out  1       write strobe, A register
latch_b         out  1       write strobe, B register
latch_o         out  1       write strobe, OUT register
state           out  3       FSM state for LED debug
halted          out  1       high in HALT

Behaviour:
- Interface: reset is synchronous and active-high. The clock is one_shot_clock. All state changes on its rising edge.
- Reset wins over run and over any state, including mid-instruction. After the reset edge: pc=0, ir=0, alu_sel=0, w_bus=0, latch_a/b/o=0, state=FETCH, halted=0.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
- Sequence: FETCH→DECODE→EXECUTE→WRITEBACK→FETCH. One transition per edge with run=1, so 4 edges per instruction. With run=0, state and all registers hold and latch strobes stay 0.
- FETCH: ir<=instr.
- DECODE, by ir[7:4]:
  - 0000–0111: alu_sel<=ir[7:4] (add, sub, mul, div, shl, shr, sqA, sqB).
  - 1111: next state HALT instead of EXECUTE.
  - All others: alu_sel holds its previous value. It is retained across non-ALU instructions so a later store reads the last ALU result.
- EXECUTE, w_bus<= by ir[7:4]:
  - 1000 (store): alu_out.
  - 1001 (load A): sw_a.
  - 1010 (load B): sw_b.
  - 1011 (output): a_reg if ir[3:2]==00, else b_reg.
  - ALU ops and 1100–1110 (NOP): w_bus holds.
- WRITEBACK: strobes are combinational on state==WRITEBACK && run. Each is high for exactly that cycle; the consumer samples on the edge ending it.
  - 1000/1001: latch_a if ir[3:2]==00; latch_b if ir[3:2]==01; no strobe if ir[3]==1.
  - 1010: latch_b.
  - 1011: latch_o.
  - Never more than one strobe high at a time.
- pc<=pc+1 on the WRITEBACK→FETCH edge. Modulo 2^ADDR_W: 0xFF wraps to 0x00 without halting.
- HALT: halted=1; pc, ir, alu_sel and w_bus frozen; strobes 0; run ignored. Only reset exits.
- w_bus is always driven (no high-Z); bus arbitration stays outside this block.

Decomposition:
- Shared package cpu_pkg:
  - state encodings.
  - opcode constants: OP_ADD..OP_SQB=0–7, OP_STORE=8, OP_LDA=9, OP_LDB=10, OP_OUT=11, OP_HALT=15.
  - DEST_A=2'b00, DEST_B=2'b01.
- One natural sub-module, instr_decoder (combinational): maps ir to {is_alu, wsrc, dest strobes, is_halt}. The FSM and registers stay in control_sequencer.

Test Plan:
1. Assert reset in EXECUTE with run=1 -> next edge: state=0, pc=0x00, ir=0x00, w_bus=0x00, all strobes 0, halted=0.
2. instr=0x90, sw_a=0x2A, 4 run edges -> ir=0x90 after edge 1; w_bus=0x2A after edge 3; latch_a=1 only during WRITEBACK; pc=0x01 after edge 4.
3. Program 0x00 (add) then 0x84 (store to B), alu_out=0x35 -> alu_sel=0 after DECODE and still 0 through the store; w_bus=0x35; latch_b pulses once; pc=0x02.
4. instr=0xB4, b_reg=0x11 -> w_bus=0x11, latch_o single pulse; latch_a=latch_b=0. Then instr=0x98 -> no strobe at all.
5. instr=0xF0 -> state=4, halted=1 after DECODE edge; pc unchanged for 10 further edges with run toggling; reset -> state=0, pc=0.
6. Drop run for 3 edges while in EXECUTE -> state stays 2, no strobe, w_bus unchanged. Separately, ROM of all 0xC0 (NOP) for 256 instructions -> pc steps 0xFF→0x00, no strobes.
